// File: rtl/hangman_game_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hangman_game_core_pkg
// Description : Shared encodings for the hangman game core: game_state codes,
//               FSM state type and the default alphabet size.
// Revision    : 1.0 - initial release
// ============================================================================
package hangman_game_core_pkg;

  // Letters in play when the instantiating level does not override it.
  localparam int ALPHABET_DEFAULT = 26;

  // game_state encodings shared with the VGA handler and the top level.
  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_WON     = 2'b01;
  localparam logic [1:0] GS_LOST    = 2'b10;

  // Controller states.
  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_PLAYING = 3'd1,
    ST_CHECK   = 3'd2,
    ST_WON     = 3'd3,
    ST_LOST    = 3'd4
  } state_e;

endpackage : hangman_game_core_pkg
`default_nettype wire

// File: rtl/hangman_game_core_letter_onehot.sv
`default_nettype none
// ============================================================================
// Module      : hangman_game_core_letter_onehot
// Description : Letter index to one-hot decoder with an in-range flag.
//               Indices at or above ALPHABET give an all-zero vector and
//               in_range = 0. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module hangman_game_core_letter_onehot
  import hangman_game_core_pkg::*;
#(
  parameter int ALPHABET = ALPHABET_DEFAULT,
  parameter int LETTER_W = 5
) (
  input  logic [LETTER_W-1:0] idx,
  output logic [ALPHABET-1:0] onehot,
  output logic                in_range
);

  // One extra bit so ALPHABET itself is representable in the comparison.
  localparam logic [LETTER_W:0] C_ALPHA = (LETTER_W+1)'(ALPHABET);

  // Decode the index; out-of-range letters select nothing.
  always_comb begin
    onehot   = '0;
    in_range = ({1'b0, idx} < C_ALPHA);
    for (int i = 0; i < ALPHABET; i++) begin
      if ({1'b0, idx} == (LETTER_W+1)'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule : hangman_game_core_letter_onehot
`default_nettype wire

// File: rtl/hangman_game_core.sv
`default_nettype none
// ============================================================================
// Module      : hangman_game_core
// Description : Multi-player hangman guess handler. Latches the word mask,
//               classifies each guess as hit / miss / repeat, keeps wrong
//               count, turn order and saturating per-player scores, and
//               decides WON / LOST one cycle after each accepted guess.
// Revision    : 1.0 - initial release
// ============================================================================
module hangman_game_core
  import hangman_game_core_pkg::*;
#(
  parameter int ALPHABET    = ALPHABET_DEFAULT,
  parameter int LETTER_W    = 5,
  parameter int MAX_WRONG   = 6,
  parameter int WRONG_W     = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_game,
  input  logic                           load,
  input  logic [LETTER_W-1:0]            load_x,
  input  logic [ALPHABET-1:0]            mask,
  output logic [ALPHABET-1:0]            guessed_mask,
  output logic [1:0]                     game_state,
  output logic [WRONG_W-1:0]             wrong_time,
  output logic [1:0]                     current_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           busy,
  output logic                           hit,
  output logic                           repeat_guess
);

  localparam logic [WRONG_W-1:0] C_MAX_WRONG   = WRONG_W'(MAX_WRONG);
  localparam logic [1:0]         C_LAST_PLAYER = 2'(NUM_PLAYERS - 1);

  state_e                state_q,   state_d;
  logic [ALPHABET-1:0]   word_q,    word_d;
  logic [ALPHABET-1:0]   guessed_q, guessed_d;
  logic [ALPHABET-1:0]   tried_q,   tried_d;
  logic [WRONG_W-1:0]    wrong_q,   wrong_d;
  logic [1:0]            player_q,  player_d;
  logic                  hit_q,     hit_d;
  logic                  rep_q,     rep_d;
  logic [SCORE_W-1:0]    score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]    score_d [NUM_PLAYERS];

  logic [ALPHABET-1:0]   letter_oh;
  logic                  letter_ok;
  logic                  clear_all;
  logic                  is_repeat;
  logic                  is_hit;

  hangman_game_core_letter_onehot #(
    .ALPHABET (ALPHABET),
    .LETTER_W (LETTER_W)
  ) u_letter_onehot (
    .idx      (load_x),
    .onehot   (letter_oh),
    .in_range (letter_ok)
  );

  // A letter counts as tried whether it was a hit or a miss.
  assign is_repeat = |(letter_oh & (guessed_q | tried_q));
  assign is_hit    = |(letter_oh & word_q);

  // Next-state logic: new_game restart, guess classification and win/lose check.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    guessed_d = guessed_q;
    tried_d   = tried_q;
    wrong_d   = wrong_q;
    player_d  = player_q;
    hit_d     = 1'b0;
    rep_d     = 1'b0;
    clear_all = 1'b0;

    if (new_game && (state_q != ST_START)) begin
      // Restart keeps no history; the word is re-latched in START.
      clear_all = 1'b1;
      state_d   = ST_START;
      word_d    = '0;
      guessed_d = '0;
      tried_d   = '0;
      wrong_d   = '0;
      player_d  = '0;
    end else begin
      case (state_q)
        ST_START: begin
          // RAM data is valid by now; freeze it for the whole game.
          word_d  = mask;
          state_d = ST_PLAYING;
        end
        ST_PLAYING: begin
          if (load && letter_ok) begin
            state_d = ST_CHECK;
            if (is_repeat) begin
              rep_d = 1'b1;
            end else if (is_hit) begin
              guessed_d = guessed_q | letter_oh;
              hit_d     = 1'b1;
            end else begin
              tried_d = tried_q | letter_oh;
              if (wrong_q != C_MAX_WRONG) begin
                wrong_d = wrong_q + WRONG_W'(1);
              end
              player_d = (player_q == C_LAST_PLAYER) ? 2'd0 : player_q + 2'd1;
            end
          end
        end
        ST_CHECK: begin
          // An empty word can never be completed, so it can only be lost.
          if ((word_q != '0) && ((guessed_q & word_q) == word_q)) begin
            state_d = ST_WON;
          end else if (wrong_q == C_MAX_WRONG) begin
            state_d = ST_LOST;
          end else begin
            state_d = ST_PLAYING;
          end
        end
        ST_WON, ST_LOST: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_START;
        end
      endcase
    end
  end

  // Controller and game-progress registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_START;
      word_q    <= '0;
      guessed_q <= '0;
      tried_q   <= '0;
      wrong_q   <= '0;
      player_q  <= '0;
      hit_q     <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      guessed_q <= guessed_d;
      tried_q   <= tried_d;
      wrong_q   <= wrong_d;
      player_q  <= player_d;
      hit_q     <= hit_d;
      rep_q     <= rep_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    // Credit a new correct letter to the player whose turn it is, saturating.
    always_comb begin
      score_d[p] = score_q[p];
      if (clear_all) begin
        score_d[p] = '0;
      end else if (hit_d && (player_q == 2'(p)) && (score_q[p] != '1)) begin
        score_d[p] = score_q[p] + SCORE_W'(1);
      end
    end

    // Per-player score register.
    always_ff @(posedge clk) begin
      if (reset) begin
        score_q[p] <= '0;
      end else begin
        score_q[p] <= score_d[p];
      end
    end

    assign scores[p*SCORE_W +: SCORE_W] = score_q[p];
  end

  assign guessed_mask   = guessed_q;
  assign wrong_time     = wrong_q;
  assign current_player = player_q;
  assign hit            = hit_q;
  assign repeat_guess   = rep_q;
  assign busy           = (state_q == ST_START) || (state_q == ST_CHECK);
  assign game_state     = (state_q == ST_WON)  ? GS_WON  :
                          (state_q == ST_LOST) ? GS_LOST : GS_PLAYING;

endmodule : hangman_game_core
`default_nettype wire

// File: tb/tb_hangman_game_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_hangman_game_core
// Description : Self-checking bench for hangman_game_core. Each accepted
//               guess pushes its expected CHECK-cycle outputs and following
//               game_state into a queue; a monitor pops one entry for every
//               busy CHECK cycle the DUT shows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hangman_game_core;

  localparam logic [25:0] W_CAT = 26'h0080005;  // C=2, A=0, T=19
  localparam logic [25:0] W_DOG = 26'h0004048;  // D=3, O=14, G=6

  typedef struct {
    int          id;
    logic [25:0] gm;
    logic [3:0]  wt;
    logic [1:0]  pl;
    logic [7:0]  sc;
    logic        hit;
    logic        rep;
    logic [1:0]  gs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0, new_game = 1'b0, load = 1'b0;
  logic [4:0]  load_x = '0;
  logic [25:0] mask = W_CAT;
  logic [25:0] guessed_mask;
  logic [1:0]  game_state, current_player;
  logic [3:0]  wrong_time;
  logic [7:0]  scores;
  logic        busy, hit, repeat_guess;

  logic        reset2 = 1'b0, load2 = 1'b0;
  logic [4:0]  load_x2 = '0;
  logic [25:0] mask2 = 26'h000003F;
  logic [25:0] guessed_mask2;
  logic [1:0]  game_state2, current_player2;
  logic [3:0]  wrong_time2, scores2;
  logic        busy2, hit2, repeat_guess2;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          start_skip = 0;
  int          id_ctr = 0;
  bit          mon_en = 1'b0;
  bit          pending_gs = 1'b0;
  logic [1:0]  exp_gs_hold = '0;

  always #5 clk = ~clk;

  hangman_game_core dut (
    .clk(clk), .reset(reset), .new_game(new_game), .load(load), .load_x(load_x),
    .mask(mask), .guessed_mask(guessed_mask), .game_state(game_state),
    .wrong_time(wrong_time), .current_player(current_player), .scores(scores),
    .busy(busy), .hit(hit), .repeat_guess(repeat_guess)
  );

  hangman_game_core #(.SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset2), .new_game(1'b0), .load(load2), .load_x(load_x2),
    .mask(mask2), .guessed_mask(guessed_mask2), .game_state(game_state2),
    .wrong_time(wrong_time2), .current_player(current_player2), .scores(scores2),
    .busy(busy2), .hit(hit2), .repeat_guess(repeat_guess2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [25:0] gm, input logic [3:0] wt, input logic [1:0] pl,
                      input logic [7:0] sc, input logic h, input logic r, input logic [1:0] gs);
    exp_t e;
    e.id = id_ctr; e.gm = gm; e.wt = wt; e.pl = pl; e.sc = sc;
    e.hit = h; e.rep = r; e.gs = gs;
    id_ctr++;
    sb.push_back(e);
  endtask

  // Called at posedge+1; leaves at posedge+1 two edges later.
  task automatic do_guess(input logic [4:0] x);
    load = 1'b1; load_x = x;
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); start_skip++; mon_en = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_guessed", guessed_mask, 0);
    chk("rst_wrong", wrong_time, 0);
    chk("rst_player", current_player, 0);
    chk("rst_scores", scores, 0);
    chk("rst_state", game_state, 0);
    chk("rst_pulses", {hit, repeat_guess}, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: one scoreboard entry per CHECK cycle, game_state one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pending_gs) begin
          chk($sformatf("g%0d_state", e.id), game_state, exp_gs_hold);
          pending_gs = 1'b0;
        end
        if (busy === 1'b1 && start_skip > 0) begin
          start_skip--;
        end else if (busy === 1'b1) begin
          if (sb.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_check: busy=1 expected no guess in flight (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk($sformatf("g%0d_guessed", e.id), guessed_mask, e.gm);
            chk($sformatf("g%0d_wrong", e.id), wrong_time, e.wt);
            chk($sformatf("g%0d_player", e.id), current_player, e.pl);
            chk($sformatf("g%0d_scores", e.id), scores, e.sc);
            chk($sformatf("g%0d_hit", e.id), hit, e.hit);
            chk($sformatf("g%0d_repeat", e.id), repeat_guess, e.rep);
            exp_gs_hold = e.gs;
            pending_gs = 1'b1;
          end
        end else begin
          chk("idle_pulses", {hit, repeat_guess}, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2 [5];
    exp2 = '{1, 2, 3, 3, 3};
    #3;
    // 1: C, A, T -> win for player 0
    do_reset();
    push(26'h0000004, 4'd0, 2'd0, 8'h01, 1'b1, 1'b0, 2'b00); do_guess(5'd2);
    push(26'h0000005, 4'd0, 2'd0, 8'h02, 1'b1, 1'b0, 2'b00); do_guess(5'd0);
    push(26'h0080005, 4'd0, 2'd0, 8'h03, 1'b1, 1'b0, 2'b01); do_guess(5'd19);
    do_guess(5'd25);  // ignored in WON
    chk("won_hold", game_state, 2'b01);

    // 2: six misses -> lost, turns alternate
    do_reset();
    push(26'h0, 4'd1, 2'd1, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd25);
    push(26'h0, 4'd2, 2'd0, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd16);
    push(26'h0, 4'd3, 2'd1, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd23);
    push(26'h0, 4'd4, 2'd0, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd9);
    push(26'h0, 4'd5, 2'd1, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd10);
    push(26'h0, 4'd6, 2'd0, 8'h00, 1'b0, 1'b0, 2'b10); do_guess(5'd21);
    do_guess(5'd2);   // ignored in LOST
    chk("lost_hold", game_state, 2'b10);
    chk("lost_guessed", guessed_mask, 0);

    // 3: hit, repeat, miss, repeat
    do_reset();
    push(26'h1, 4'd0, 2'd0, 8'h01, 1'b1, 1'b0, 2'b00); do_guess(5'd0);
    push(26'h1, 4'd0, 2'd0, 8'h01, 1'b0, 1'b1, 2'b00); do_guess(5'd0);
    push(26'h1, 4'd1, 2'd1, 8'h01, 1'b0, 1'b0, 2'b00); do_guess(5'd25);
    push(26'h1, 4'd1, 2'd1, 8'h01, 1'b0, 1'b1, 2'b00); do_guess(5'd25);

    // 4: out-of-range letter dropped; load held through CHECK dropped
    do_guess(5'd27);
    push(26'h1, 4'd2, 2'd0, 8'h01, 1'b0, 1'b0, 2'b00);
    load = 1'b1; load_x = 5'd1;
    @(posedge clk); #1 load_x = 5'd2;
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1;
    chk("hold_guessed", guessed_mask, 26'h1);
    @(posedge clk); #1;

    // 5: new_game with simultaneous load, new word DOG
    mask = W_DOG; new_game = 1'b1; load = 1'b1; load_x = 5'd2;
    @(posedge clk); start_skip++;
    #1 new_game = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("ng_guessed", guessed_mask, 0);
    chk("ng_wrong", wrong_time, 0);
    chk("ng_scores", scores, 0);
    chk("ng_player", current_player, 0);
    @(posedge clk); #1;
    mask = W_CAT;  // not seen without a restart
    push(26'h0000008, 4'd0, 2'd0, 8'h01, 1'b1, 1'b0, 2'b00); do_guess(5'd3);
    push(26'h0004008, 4'd0, 2'd0, 8'h02, 1'b1, 1'b0, 2'b00); do_guess(5'd14);
    push(26'h0004048, 4'd0, 2'd0, 8'h03, 1'b1, 1'b0, 2'b01); do_guess(5'd6);

    // 6: reset during CHECK of the sixth miss aborts the LOST decision
    do_reset();
    push(26'h0, 4'd1, 2'd1, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd25);
    push(26'h0, 4'd2, 2'd0, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd16);
    push(26'h0, 4'd3, 2'd1, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd23);
    push(26'h0, 4'd4, 2'd0, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd9);
    push(26'h0, 4'd5, 2'd1, 8'h00, 1'b0, 1'b0, 2'b00); do_guess(5'd10);
    push(26'h0, 4'd6, 2'd0, 8'h00, 1'b0, 1'b0, 2'b00);
    load = 1'b1; load_x = 5'd21;
    @(posedge clk); #1 load = 1'b0; reset = 1'b1;
    @(posedge clk); start_skip++;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_wrong", wrong_time, 0);
    chk("abort_state", game_state, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_lost", game_state, 0);
    end

    // Score saturation with SCORE_W=2
    reset2 = 1'b1;
    @(posedge clk); #1 reset2 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      load2 = 1'b1; load_x2 = 5'(i);
      @(posedge clk); #1 load2 = 1'b0;
      @(negedge clk);
      chk($sformatf("sat_score%0d", i), scores2[1:0], exp2[i]);
      chk($sformatf("sat_hit%0d", i), hit2, 1);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_hangman_game_core
`default_nettype wire
